// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE
  } loader_state_t;

  localparam int unsigned LOADER_HDR_BYTES = 2;
  localparam int unsigned BYTES_PER_WORD   = 4;

endpackage

// File: rtl/word_packer.sv
// Assembles a stream of bytes into 32-bit words in the selected byte order.
// Three bytes are held; op_word combines them with the byte currently on
// ip_byte so the completed word is available in the cycle its last byte is
// accepted.
module word_packer
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  ip_byte,
  output logic [31:0] op_word,
  output logic        op_full
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] byte_cnt;
  logic [23:0]      held;

  // Byte counter and holding register; the counter wraps after the last byte.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_cnt <= '0;
      held     <= '0;
    end else if (shift_en) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
      held     <= BIG_ENDIAN ? {held[15:0], ip_byte} : {ip_byte, held[23:8]};
    end
  end

  // High when the next shifted byte completes the word.
  assign op_full = (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign op_word = BIG_ENDIAN ? {held, ip_byte} : {ip_byte, held};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes 32-bit words
// to consecutive instruction-memory addresses and holds the core in reset
// until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ip_start,
  input  logic              ip_byte_valid,
  input  logic [7:0]        ip_byte,
  output logic              op_ready,
  output logic              op_we,
  output logic [ADDR_W-1:0] op_addr,
  output logic [31:0]       op_wdata,
  output logic              op_cpu_reset,
  output logic              op_done,
  output logic              op_error
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  loader_state_t state, state_nx;
  logic [15:0]   word_cnt;
  logic [15:0]   word_idx;
  logic [15:0]   hdr_n;
  logic [15:0]   idx_inc;
  logic          accept;
  logic          pk_clear;
  logic          pk_shift;
  logic          pk_full;
  logic [31:0]   pk_word;

  assign accept   = ip_byte_valid && op_ready;
  assign pk_shift = accept && (state == DATA);

  word_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
    .clock    (clock),
    .reset    (reset),
    .clear    (pk_clear),
    .shift_en (pk_shift),
    .ip_byte  (ip_byte),
    .op_word  (pk_word),
    .op_full  (pk_full)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode; op_ready depends on the state register alone.
  always_comb begin
    state_nx = state;
    op_ready = 1'b0;
    pk_clear = 1'b0;
    hdr_n    = {word_cnt[15:8], ip_byte};
    idx_inc  = word_idx + 16'd1;
    unique case (state)
      IDLE, DONE: begin
        if (ip_start) begin
          state_nx = HDR_HI;
          pk_clear = 1'b1;
        end
      end
      HDR_HI: begin
        op_ready = 1'b1;
        if (ip_byte_valid) state_nx = HDR_LO;
      end
      HDR_LO: begin
        op_ready = 1'b1;
        if (ip_byte_valid) state_nx = (hdr_n == 16'd0) ? DONE : DATA;
      end
      DATA: begin
        op_ready = 1'b1;
        if (ip_byte_valid && pk_full) state_nx = WRITE;
      end
      WRITE:   state_nx = (idx_inc == word_cnt) ? DONE : DATA;
      default: state_nx = IDLE;
    endcase
  end

  // Header, word index and registered outputs. The write strobe is loaded
  // on the edge that accepts the last byte so it is seen during WRITE.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_cnt     <= '0;
      word_idx     <= '0;
      op_we        <= 1'b0;
      op_addr      <= '0;
      op_wdata     <= '0;
      op_cpu_reset <= 1'b1;
      op_done      <= 1'b0;
      op_error     <= 1'b0;
    end else begin
      op_we <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (ip_start) begin
            word_idx     <= '0;
            op_cpu_reset <= 1'b1;
            op_done      <= 1'b0;
            op_error     <= 1'b0;
          end
        end
        HDR_HI: if (accept) word_cnt[15:8] <= ip_byte;
        HDR_LO: begin
          if (accept) begin
            word_cnt[7:0] <= ip_byte;
            if ({1'b0, hdr_n} > DEPTH) op_error <= 1'b1;
            if (hdr_n == 16'd0) begin
              op_cpu_reset <= 1'b0;
              op_done      <= 1'b1;
            end
          end
        end
        DATA: begin
          if (accept && pk_full) begin
            op_we    <= ({1'b0, word_idx} < DEPTH);
            op_addr  <= word_idx[ADDR_W-1:0];
            op_wdata <= pk_word;
          end
        end
        WRITE: begin
          word_idx <= idx_inc;
          if (idx_inc == word_cnt) begin
            op_cpu_reset <= 1'b0;
            op_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
